// File: rtl/dma_seq_ctrl.sv
// Two-channel DMA command sequencer: splits each channel's transfer into
// bounded commands, limits in-flight commands and reports task completion.
module dma_seq_ctrl #(
  parameter int MAX_CMD_BYTES   = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_ready,
  output logic        ap_idle,
  input  logic [31:0] rdma_transfer_byte,
  input  logic [31:0] rdma_mem_ptr,
  input  logic [31:0] wdma_transfer_byte,
  input  logic [31:0] wdma_mem_ptr,
  output logic        rdma_cmd_valid,
  input  logic        rdma_cmd_ready,
  output logic [31:0] rdma_cmd_addr,
  output logic [31:0] rdma_cmd_len,
  input  logic        rdma_cmd_done,
  output logic        wdma_cmd_valid,
  input  logic        wdma_cmd_ready,
  output logic [31:0] wdma_cmd_addr,
  output logic [31:0] wdma_cmd_len,
  input  logic        wdma_cmd_done,
  output logic        err_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0]     MAX_LEN = 32'(MAX_CMD_BYTES);
  localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);

  state_t state, state_next;

  // Index 0 is the read channel, index 1 the write channel.
  logic [1:0][31:0]   addr;
  logic [1:0][31:0]   remain;
  logic [1:0][31:0]   len;
  logic [1:0][OW-1:0] outst;
  logic [1:0]         valid;
  logic [1:0]         ready;
  logic [1:0]         done_in;
  logic [1:0]         hs;
  logic [1:0]         complete;

  assign ready   = {wdma_cmd_ready, rdma_cmd_ready};
  assign done_in = {wdma_cmd_done, rdma_cmd_done};
  assign hs      = valid & ready;

  always_comb begin
    len      = '0;
    valid    = '0;
    complete = '0;
    for (int c = 0; c < 2; c++) begin
      len[c]      = (remain[c] > MAX_LEN) ? MAX_LEN : remain[c];
      valid[c]    = (state == RUN) && (remain[c] != 32'd0) && (outst[c] < MAX_OUT);
      complete[c] = (remain[c] == 32'd0) && (outst[c] == '0);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (ap_start) state_next = RUN;
      RUN:     if (&complete) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Completion pulses are only meaningful in RUN; outside it they are dropped.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr     <= '0;
      remain   <= '0;
      outst    <= '0;
      err_done <= 1'b0;
    end else if (state == IDLE && ap_start) begin
      addr     <= {wdma_mem_ptr, rdma_mem_ptr};
      remain   <= {wdma_transfer_byte, rdma_transfer_byte};
      outst    <= '0;
      err_done <= 1'b0;
    end else if (state == RUN) begin
      for (int c = 0; c < 2; c++) begin
        if (hs[c]) begin
          addr[c]   <= addr[c] + len[c];
          remain[c] <= remain[c] - len[c];
        end
        unique case ({hs[c], done_in[c]})
          2'b10: outst[c] <= outst[c] + OW'(1);
          2'b01: begin
            if (outst[c] == '0) err_done <= 1'b1;
            else                outst[c] <= outst[c] - OW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);
  assign ap_ready = (state == DONE);

  assign rdma_cmd_valid = valid[0];
  assign rdma_cmd_addr  = addr[0];
  assign rdma_cmd_len   = len[0];
  assign wdma_cmd_valid = valid[1];
  assign wdma_cmd_addr  = addr[1];
  assign wdma_cmd_len   = len[1];

endmodule
